// File: rtl/tqvp_bus_arbiter.sv
// Two-requester round-robin arbiter with a single-owner IDLE/ACCESS/DONE register-bus sequencer.
// Grant in 1 cycle, write 3 cycles grant-to-IDLE, reads stall on data_ready; optional read timeout under TQVP_ARB_TIMEOUT_EN.
module tqvp_bus_arbiter #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic        a_we,
    input  logic [1:0]  a_width,
    input  logic [5:0]  a_addr,
    input  logic [31:0] a_wdata,
    input  logic        b_valid,
    input  logic        b_we,
    input  logic [1:0]  b_width,
    input  logic [5:0]  b_addr,
    input  logic [31:0] b_wdata,
    output logic        a_ready,
    output logic        b_ready,
    output logic        a_done,
    output logic        b_done,
    output logic        a_err,
    output logic        b_err,
    output logic [31:0] rdata,
    output logic [5:0]  address,
    output logic [31:0] data_in,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_out,
    input  logic        data_ready
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nxt;
    logic        last_b;
    logic        owner_b;
    logic        we_q;
    logic        err_q;
    logic [1:0]  width_q;
    logic        grant_a, grant_b;
    logic        req_we;
    logic [1:0]  req_width;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rd_hit;
    logic        rd_timeout;
    logic [31:0] rd_masked;

    // last_b=1 means B was served last, so A wins the next tie
    always_comb begin
        grant_a   = (state == IDLE) && a_valid && (!b_valid || last_b);
        grant_b   = (state == IDLE) && b_valid && (!a_valid || !last_b);
        req_we    = grant_b ? b_we    : a_we;
        req_width = grant_b ? b_width : a_width;
        req_addr  = grant_b ? b_addr  : a_addr;
        req_wdata = grant_b ? b_wdata : a_wdata;
    end

    assign rd_hit = (state == ACCESS) && !we_q && data_ready;

`ifdef TQVP_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != ACCESS) begin
            wait_cnt <= '0;
        end else if (!we_q) begin
            wait_cnt <= wait_cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end
    end

    assign rd_timeout = (state == ACCESS) && !we_q && !data_ready && (wait_cnt == {TIMEOUT_W{1'b1}});
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_W;
    assign rd_timeout = 1'b0;
`endif

    always_comb begin
        case (width_q)
            2'b00:   rd_masked = {24'h0, data_out[7:0]};
            2'b01:   rd_masked = {16'h0, data_out[15:0]};
            default: rd_masked = data_out;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_a || grant_b) begin
                    state_nxt = (req_width == 2'b11) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (we_q || data_ready || rd_timeout) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_b  <= 1'b1;
            owner_b <= 1'b0;
            we_q    <= 1'b0;
            width_q <= 2'b00;
            err_q   <= 1'b0;
            address <= '0;
            data_in <= '0;
            rdata   <= '0;
        end else begin
            state <= state_nxt;
            if (grant_a || grant_b) begin
                last_b  <= grant_b;
                owner_b <= grant_b;
                we_q    <= req_we;
                width_q <= req_width;
                err_q   <= (req_width == 2'b11);
                address <= req_addr;
                data_in <= req_wdata;
                rdata   <= '0;
            end
            if (rd_hit) begin
                rdata <= rd_masked;
            end else if (rd_timeout) begin
                err_q <= 1'b1;
                rdata <= '0;
            end
        end
    end

    // Outputs are held quiet while rst is asserted, whatever state is still registered
    always_comb begin
        a_ready      = grant_a && !rst;
        b_ready      = grant_b && !rst;
        a_done       = (state == DONE) && !owner_b && !rst;
        b_done       = (state == DONE) &&  owner_b && !rst;
        a_err        = a_done && err_q;
        b_err        = b_done && err_q;
        data_write_n = ((state == ACCESS) &&  we_q && !rst) ? width_q : 2'b11;
        data_read_n  = ((state == ACCESS) && !we_q && !rst) ? width_q : 2'b11;
    end

endmodule

// File: tb/tb_tqvp_bus_arbiter.sv
// Directed and randomized checks of tqvp_bus_arbiter against a transaction-level reference model.
module tb_tqvp_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_we = 1'b0, b_we = 1'b0;
    logic [1:0]  a_width = 2'b00, b_width = 2'b00;
    logic [5:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic        a_ready, b_ready, a_done, b_done, a_err, b_err;
    logic [31:0] rdata;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n, data_read_n;
    logic [31:0] data_out = '0;
    logic        data_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    // Requester stimulus, index 0 = A, 1 = B
    logic        r_we[2];
    logic [1:0]  r_width[2];
    logic [5:0]  r_addr[2];
    logic [31:0] r_wdata[2];
    int          last_w;  // model: who was granted last (1 after reset so A wins first tie)

    tqvp_bus_arbiter #(.TIMEOUT_W(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_we(a_we), .a_width(a_width), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_we(b_we), .b_width(b_width), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_ready(a_ready), .b_ready(b_ready), .a_done(a_done), .b_done(b_done),
        .a_err(a_err), .b_err(b_err), .rdata(rdata), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask_rd(input logic [31:0] d, input logic [1:0] w);
        case (w)
            2'b00:   return d & 32'h0000_00FF;
            2'b01:   return d & 32'h0000_FFFF;
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] flags_exp(input int w, input logic done, input logic err);
        return {done && w == 0, done && w == 1, done && err && w == 0, done && err && w == 1};
    endfunction

    task automatic drive_req(input logic av, input logic bv);
        a_valid = av;          b_valid = bv;
        a_we    = r_we[0];     b_we    = r_we[1];
        a_width = r_width[0];  b_width = r_width[1];
        a_addr  = r_addr[0];   b_addr  = r_addr[1];
        a_wdata = r_wdata[0];  b_wdata = r_wdata[1];
    endtask

    task automatic scramble_req();
        a_we = 1'($urandom);     b_we = 1'($urandom);
        a_width = 2'($urandom);  b_width = 2'($urandom);
        a_addr = 6'($urandom);   b_addr = 6'($urandom);
        a_wdata = $urandom;      b_wdata = $urandom;
    endtask

    task automatic set_req(input int i, input logic we, input logic [1:0] w,
                           input logic [5:0] ad, input logic [31:0] wd);
        r_we[i] = we; r_width[i] = w; r_addr[i] = ad; r_wdata[i] = wd;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_wr_n"}, 32'(data_write_n), 32'd3);
        chk({tag, "_rd_n"}, 32'(data_read_n), 32'd3);
        chk({tag, "_flags"}, 32'({a_done, b_done, a_err, b_err}), 32'd0);
    endtask

    // Called mid-cycle with the DUT in IDLE; returns mid-cycle in the following IDLE cycle.
    task automatic txn(input logic av, input logic bv, input int rdelay, input logic [31:0] pdata);
        int w;
        logic we; logic [1:0] wd; logic [5:0] ad; logic [31:0] wdat;
        drive_req(av, bv);
        data_ready = 1'($urandom);
        data_out   = $urandom;
        #1;
        w = (av && bv) ? (last_w == 1 ? 0 : 1) : (av ? 0 : 1);
        chk("ready", 32'({a_ready, b_ready}), (w == 0) ? 32'd2 : 32'd1);
        last_w = w;
        we = r_we[w]; wd = r_width[w]; ad = r_addr[w]; wdat = r_wdata[w];
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        scramble_req();
        if (wd == 2'b11) begin
            #1;
            chk("ill_wr_n", 32'(data_write_n), 32'd3);
            chk("ill_rd_n", 32'(data_read_n), 32'd3);
            chk("ill_flags", 32'({a_done, b_done, a_err, b_err}), 32'(flags_exp(w, 1'b1, 1'b1)));
        end else if (we) begin
            data_ready = 1'($urandom);
            #1;
            chk("wr_strobe", 32'(data_write_n), 32'(wd));
            chk("wr_rd_n", 32'(data_read_n), 32'd3);
            chk("wr_addr", 32'(address), 32'(ad));
            chk("wr_data", data_in, wdat);
            chk("wr_noflag", 32'({a_done, b_done, a_err, b_err}), 32'd0);
            @(negedge clk);
            #1;
            chk("wr_done_wr_n", 32'(data_write_n), 32'd3);
            chk("wr_done", 32'({a_done, b_done, a_err, b_err}), 32'(flags_exp(w, 1'b1, 1'b0)));
        end else begin
            for (int k = 0; k <= rdelay; k++) begin
                if (k > 0) @(negedge clk);
                data_ready = (k == rdelay);
                data_out   = (k == rdelay) ? pdata : $urandom;
                #1;
                chk("rd_strobe", 32'(data_read_n), 32'(wd));
                chk("rd_wr_n", 32'(data_write_n), 32'd3);
                chk("rd_addr", 32'(address), 32'(ad));
                chk("rd_noflag", 32'({a_done, b_done, a_err, b_err}), 32'd0);
            end
            @(negedge clk);
            data_ready = 1'($urandom);
            data_out   = $urandom;
            #1;
            chk("rd_done", 32'({a_done, b_done, a_err, b_err}), 32'(flags_exp(w, 1'b1, 1'b0)));
            chk("rd_data", rdata, mask_rd(pdata, wd));
            chk("rd_done_rd_n", 32'(data_read_n), 32'd3);
        end
        @(negedge clk);
        data_ready = 1'b0;
        #1;
        chk_idle("post");
    endtask

    initial begin
        int stall;
        last_w = 1;
        for (int i = 0; i < 2; i++) set_req(i, 1'b0, 2'b00, 6'd0, 32'd0);

        // Reset: outputs quiet even with a request present
        a_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", 32'({a_ready, b_ready}), 32'd0);
        chk_idle("rst");
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_data_in", data_in, 32'd0);
        a_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // A word write
        set_req(0, 1'b1, 2'b10, 6'h05, 32'hDEAD_BEEF);
        txn(1'b1, 1'b0, 0, 32'h0);

        // B byte read, data_ready on the third ACCESS cycle
        set_req(1, 1'b0, 2'b00, 6'h10, 32'h0);
        txn(1'b0, 1'b1, 2, 32'h1234_5678);

        // Illegal width
        set_req(0, 1'b1, 2'b11, 6'h01, 32'h1);
        txn(1'b1, 1'b0, 0, 32'h0);

        // Both held valid right after reset: A,B,A,B every 3 cycles
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_w = 1;
        set_req(0, 1'b1, 2'b10, 6'h0A, 32'hAAAA_0000);
        set_req(1, 1'b1, 2'b01, 6'h0B, 32'hBBBB_0000);
        drive_req(1'b1, 1'b1);
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("tie_ready", 32'({a_ready, b_ready}),
                (c % 3 != 0) ? 32'd0 : (((c / 3) % 2 == 0) ? 32'd2 : 32'd1));
            @(negedge clk);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        last_w = 1;
        #1;
        chk_idle("tie_end");

        // Read that never sees data_ready
        set_req(0, 1'b0, 2'b01, 6'h2A, 32'h0);
        drive_req(1'b1, 1'b0);
        #1;
        chk("stall_ready", 32'({a_ready, b_ready}), 32'd2);
        last_w = 0;
        @(negedge clk);
        a_valid = 1'b0;
`ifdef TQVP_ARB_TIMEOUT_EN
        stall = 16;
`else
        stall = 40;
`endif
        for (int k = 0; k < stall; k++) begin
            #1;
            chk("stall_rd_n", 32'(data_read_n), 32'd1);
            chk("stall_noflag", 32'({a_done, b_done, a_err, b_err}), 32'd0);
            @(negedge clk);
        end
`ifdef TQVP_ARB_TIMEOUT_EN
        #1;
        chk("tmo_flags", 32'({a_done, b_done, a_err, b_err}), 32'(flags_exp(0, 1'b1, 1'b1)));
        chk("tmo_rdata", rdata, 32'd0);
`else
        data_ready = 1'b1;
        data_out   = 32'hCAFE_F00D;
        #1;
        chk("late_rd_n", 32'(data_read_n), 32'd1);
        @(negedge clk);
        data_ready = 1'b0;
        #1;
        chk("late_flags", 32'({a_done, b_done, a_err, b_err}), 32'(flags_exp(0, 1'b1, 1'b0)));
        chk("late_rdata", rdata, 32'h0000_F00D);
`endif
        @(negedge clk);
        #1;
        chk_idle("stall_end");

        // Reset during an A read: abandoned, and the next tie still goes to A
        set_req(0, 1'b0, 2'b10, 6'h33, 32'h0);
        drive_req(1'b1, 1'b0);
        #1;
        chk("rr_ready", 32'({a_ready, b_ready}), 32'd2);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        chk("rr_rd_n", 32'(data_read_n), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_w = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk_idle("rr_after");
        end
        set_req(0, 1'b1, 2'b00, 6'h01, 32'h11);
        set_req(1, 1'b1, 2'b00, 6'h02, 32'h22);
        txn(1'b1, 1'b1, 0, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic av, bv;
            for (int i = 0; i < 2; i++) begin
                set_req(i, 1'($urandom), ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                        6'($urandom), $urandom);
            end
            av = 1'($urandom);
            bv = av ? 1'($urandom) : 1'b1;
            txn(av, bv, int'($urandom_range(0, 5)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tqvp_bus_arbiter.md
TQVP_BUS_ARBITER -- requirements
Module: tqvp_bus_arbiter

Interface
- REQ-001 Parameter TIMEOUT_W, default 8: width of the read-wait timeout counter.
- REQ-002 clk  input  1  single clock; all logic on rising edge.
- REQ-003 rst  input  1  synchronous, active-high reset.
- REQ-004 a_valid / b_valid  input  1  requester A (SPI bridge) / B (local sequencer) has a request pending.
- REQ-005 a_we / b_we  input  1  1 = write, 0 = read.
- REQ-006 a_width / b_width  input  2  transaction width: 00 byte, 01 half, 10 word, 11 illegal.
- REQ-007 a_addr / b_addr  input  6  register address.
- REQ-008 a_wdata / b_wdata  input  32  write data.
- REQ-009 a_ready / b_ready  output  1  one-cycle pulse: request accepted and latched.
- REQ-010 a_done / b_done  output  1  one-cycle pulse: transaction complete.
- REQ-011 a_err / b_err  output  1  valid with done; 1 = illegal width or timeout.
- REQ-012 rdata  output  32  read result, valid while either done is high.
- REQ-013 address  output  6  peripheral register address.
- REQ-014 data_in  output  32  peripheral write data.
- REQ-015 data_write_n / data_read_n  output  2  peripheral strobes; 11 = idle, otherwise the width code.
- REQ-016 data_out  input  32  peripheral read data.
- REQ-017 data_ready  input  1  peripheral read-data-valid.

Function
- REQ-018 FSM states SHALL be IDLE, ACCESS and DONE.
- REQ-019 In IDLE with any valid high, the arbiter SHALL pulse the winner's ready, latch its request, and go to ACCESS the next cycle.
- REQ-020 Arbitration SHALL be round-robin: if both are valid, the requester not granted last wins; a single valid requester always wins.
- REQ-021 A request with width 11 SHALL be accepted, SHALL skip ACCESS (no strobe driven), and SHALL go to DONE with err=1.
- REQ-022 Write in ACCESS: data_write_n = width for exactly one cycle, then DONE.
- REQ-023 Read in ACCESS: data_read_n = width, held until data_ready is sampled 1; that cycle SHALL capture data_out into rdata, then go to DONE.
- REQ-024 Captured rdata SHALL be masked: byte clears [31:8], half clears [31:16], word unmasked.
- REQ-025 DONE SHALL last one cycle with the owner's done=1, then return to IDLE; no new grant is made in DONE.
- REQ-026 A write SHALL take 3 cycles from grant to IDLE; the minimum request-to-request spacing is 3 cycles.
- REQ-027 address and data_in SHALL hold the latched values throughout ACCESS; both strobes SHALL be 11 outside ACCESS.
- REQ-028 Request inputs SHALL be ignored outside IDLE; valid deasserting after grant SHALL NOT abort the transaction.
- REQ-029 data_ready outside a read ACCESS SHALL be ignored.

Reset
- REQ-030 On rst=1: state IDLE, round-robin pointer set so A wins the first tie, all ready/done/err 0, rdata 0, address 0, data_in 0, strobes 11.
- REQ-031 Reset mid-transaction SHALL abandon it without a done pulse; strobes SHALL be 11 in the cycle after rst is sampled.

Configuration
- REQ-032 Macro TQVP_ARB_TIMEOUT_EN defined: a read ACCESS lasting 2^TIMEOUT_W cycles without data_ready SHALL end in DONE with err=1 and rdata=0.
- REQ-033 Macro TQVP_ARB_TIMEOUT_EN undefined: no counter is built, and a read waits for data_ready indefinitely.

Verification
- REQ-034 A writes width=10, addr=0x05, wdata=0xDEADBEEF -> a_ready at the grant, then data_write_n=10 for 1 cycle with address=0x05 and data_in=0xDEADBEEF, then a_done with err=0.
- REQ-035 B reads width=00, addr=0x10, peripheral returns data_out=0x12345678 with data_ready three cycles later -> data_read_n=00 held for 3 cycles, rdata=0x00000078, b_done=1.
- REQ-036 A and B both held valid -> grants alternate A,B,A,B; after reset the first grant goes to A.
- REQ-037 A request with width=11 -> strobes stay 11 throughout, then a_done=1 and a_err=1.
- REQ-038 With TQVP_ARB_TIMEOUT_EN and TIMEOUT_W=4, a read that never gets data_ready -> done and err after 16 ACCESS cycles, rdata=0.
- REQ-039 rst=1 asserted during a read ACCESS -> strobes return to 11 the next cycle, no done pulse, and the next tie is granted to A.
